// File: rtl/load_store_unit.sv
// RV32I memory stage: issues byte/half/word loads and stores over a req/gnt/rvalid port,
// aligns and extends load data and drives the register-file write port.
module load_store_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        START,
    input  logic        OP_LOAD,
    input  logic        OP_STORE,
    input  logic [2:0]  FUNCT3,
    input  logic [31:0] ADDR,
    input  logic [31:0] STORE_DATA,
    input  logic [4:0]  RD,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic [1:0]  ERR_CAUSE,
    output logic        MEM_REQ,
    output logic        MEM_WE,
    output logic [31:0] MEM_ADDR,
    output logic [3:0]  MEM_BE,
    output logic [31:0] MEM_WDATA,
    input  logic        MEM_GNT,
    input  logic        MEM_RVALID,
    input  logic [31:0] MEM_RDATA,
    output logic        WB_WE,
    output logic [4:0]  WB_REG,
    output logic [31:0] WB_DATA
);
    localparam int CW = $clog2(TIMEOUT + 2);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT_R, S_WB, S_DONE_S, S_ERRS} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    funct3_q, funct3_d;
    logic [1:0]    lane_q, lane_d;
    logic [4:0]    rd_q, rd_d;
    logic [1:0]    err_cause_q, err_cause_d;
    logic          mem_we_q, mem_we_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [3:0]    mem_be_q, mem_be_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic [31:0]   wb_data_q, wb_data_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          mem_req_q, mem_req_d;
    logic          wb_we_q, wb_we_d;

    logic          ld_ok, st_ok, illegal, misaligned, timed_out;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [31:0]   ld_result;

    assign ld_ok      = FUNCT3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    assign st_ok      = FUNCT3 inside {3'b000, 3'b001, 3'b010};
    assign illegal    = (OP_LOAD && OP_STORE) || (OP_LOAD ? !ld_ok : !st_ok);
    assign misaligned = ((FUNCT3[1:0] == 2'b01) && ADDR[0]) ||
                        ((FUNCT3[1:0] == 2'b10) && (ADDR[1:0] != 2'b00));
    assign timed_out  = (TIMEOUT != 0) && (int'(cnt_q) == TIMEOUT - 1);

    // Lane extraction uses the address captured at START, not the live ADDR input.
    always_comb begin
        case (lane_q)
            2'd0:    ld_byte = MEM_RDATA[7:0];
            2'd1:    ld_byte = MEM_RDATA[15:8];
            2'd2:    ld_byte = MEM_RDATA[23:16];
            default: ld_byte = MEM_RDATA[31:24];
        endcase
        ld_half = lane_q[1] ? MEM_RDATA[31:16] : MEM_RDATA[15:0];
        case (funct3_q)
            3'b000:  ld_result = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_result = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_result = {24'd0, ld_byte};
            3'b101:  ld_result = {16'd0, ld_half};
            default: ld_result = MEM_RDATA;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;
        funct3_d    = funct3_q;
        lane_d      = lane_q;
        rd_d        = rd_q;
        err_cause_d = err_cause_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        wb_data_d   = wb_data_q;

        case (state_q)
            S_IDLE: begin
                if (START && (OP_LOAD || OP_STORE)) begin
                    err_cause_d = 2'b00;
                    funct3_d    = FUNCT3;
                    lane_d      = ADDR[1:0];
                    rd_d        = RD;
                    mem_we_d    = OP_STORE;
                    mem_addr_d  = {ADDR[31:2], 2'b00};
                    case (FUNCT3[1:0])
                        2'b00: begin
                            mem_be_d    = 4'b0001 << ADDR[1:0];
                            mem_wdata_d = {4{STORE_DATA[7:0]}};
                        end
                        2'b01: begin
                            mem_be_d    = ADDR[1] ? 4'b1100 : 4'b0011;
                            mem_wdata_d = {2{STORE_DATA[15:0]}};
                        end
                        default: begin
                            mem_be_d    = 4'b1111;
                            mem_wdata_d = STORE_DATA;
                        end
                    endcase
                    if (illegal) begin
                        state_d     = S_ERRS;
                        err_cause_d = 2'b10;
                    end else if (misaligned) begin
                        state_d     = S_ERRS;
                        err_cause_d = 2'b01;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (MEM_GNT) begin
                    state_d = mem_we_q ? S_DONE_S : S_WAIT_R;
                end else if (timed_out) begin
                    state_d     = S_ERRS;
                    err_cause_d = 2'b11;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WAIT_R: begin
                if (MEM_RVALID) begin
                    state_d   = S_WB;
                    wb_data_d = ld_result;
                end else if (timed_out) begin
                    state_d     = S_ERRS;
                    err_cause_d = 2'b11;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they come straight out of flops.
        busy_d    = (state_d != S_IDLE);
        mem_req_d = (state_d == S_REQ);
        done_d    = (state_d == S_WB) || (state_d == S_DONE_S) || (state_d == S_ERRS);
        err_d     = (state_d == S_ERRS);
        wb_we_d   = (state_d == S_WB) && (rd_d != 5'd0);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            funct3_q    <= '0;
            lane_q      <= '0;
            rd_q        <= '0;
            err_cause_q <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            wb_data_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            mem_req_q   <= 1'b0;
            wb_we_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            funct3_q    <= funct3_d;
            lane_q      <= lane_d;
            rd_q        <= rd_d;
            err_cause_q <= err_cause_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            wb_data_q   <= wb_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            mem_req_q   <= mem_req_d;
            wb_we_q     <= wb_we_d;
        end
    end

    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign ERR       = err_q;
    assign ERR_CAUSE = err_cause_q;
    assign MEM_REQ   = mem_req_q;
    assign MEM_WE    = mem_we_q;
    assign MEM_ADDR  = mem_addr_q;
    assign MEM_BE    = mem_be_q;
    assign MEM_WDATA = mem_wdata_q;
    assign WB_WE     = wb_we_q;
    assign WB_REG    = rd_q;
    assign WB_DATA   = wb_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: loads, stores, error paths, timeout and async reset.
module tb_load_store_unit;
    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        START = 1'b0, OP_LOAD = 1'b0, OP_STORE = 1'b0;
    logic [2:0]  FUNCT3 = '0;
    logic [31:0] ADDR = '0, STORE_DATA = '0;
    logic [4:0]  RD = '0;
    logic        BUSY, DONE, ERR, MEM_REQ, MEM_WE, WB_WE;
    logic [1:0]  ERR_CAUSE;
    logic [31:0] MEM_ADDR, MEM_WDATA, WB_DATA;
    logic [3:0]  MEM_BE;
    logic [4:0]  WB_REG;
    logic        MEM_GNT = 1'b0, MEM_RVALID = 1'b0;
    logic [31:0] MEM_RDATA = '0;

    int total = 0;
    int bad = 0;

    load_store_unit #(.TIMEOUT(16)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .START(START), .OP_LOAD(OP_LOAD), .OP_STORE(OP_STORE),
        .FUNCT3(FUNCT3), .ADDR(ADDR), .STORE_DATA(STORE_DATA), .RD(RD),
        .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .ERR_CAUSE(ERR_CAUSE),
        .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_BE(MEM_BE),
        .MEM_WDATA(MEM_WDATA), .MEM_GNT(MEM_GNT), .MEM_RVALID(MEM_RVALID), .MEM_RDATA(MEM_RDATA),
        .WB_WE(WB_WE), .WB_REG(WB_REG), .WB_DATA(WB_DATA)
    );

    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sdata, input logic [4:0] rd);
        START = 1'b1; OP_LOAD = ld; OP_STORE = st; FUNCT3 = f3;
        ADDR = addr; STORE_DATA = sdata; RD = rd;
        tick();
        START = 1'b0; OP_LOAD = 1'b0; OP_STORE = 1'b0;
    endtask

    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [4:0] rd, input logic [31:0] rdata,
                           input logic [31:0] exp_data, input logic exp_we);
        issue(1'b1, 1'b0, f3, addr, 32'h0, rd);
        check_val({tag, " req"}, 32'(MEM_REQ), 32'd1);
        check_val({tag, " addr"}, MEM_ADDR, {addr[31:2], 2'b00});
        check_val({tag, " we"}, 32'(MEM_WE), 32'd0);
        MEM_GNT = 1'b1;
        tick();
        MEM_GNT = 1'b0;
        check_val({tag, " req drop"}, 32'(MEM_REQ), 32'd0);
        check_val({tag, " early done"}, 32'(DONE), 32'd0);
        MEM_RVALID = 1'b1; MEM_RDATA = rdata;
        tick();
        MEM_RVALID = 1'b0; MEM_RDATA = 32'h0;
        check_val({tag, " done"}, 32'(DONE), 32'd1);
        check_val({tag, " wb_we"}, 32'(WB_WE), 32'(exp_we));
        check_val({tag, " wb_data"}, WB_DATA, exp_data);
        if (exp_we) check_val({tag, " wb_reg"}, 32'(WB_REG), 32'(rd));
        tick();
        check_val({tag, " idle"}, {30'd0, BUSY, WB_WE}, 32'd0);
        $display("load  %s addr=0x%08h rdata=0x%08h -> wb_data=0x%08h", tag, addr, rdata, WB_DATA);
    endtask

    task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] sdata, input logic [3:0] exp_be,
                            input logic [31:0] exp_wdata);
        issue(1'b0, 1'b1, f3, addr, sdata, 5'd7);
        check_val({tag, " req"}, 32'(MEM_REQ), 32'd1);
        check_val({tag, " we"}, 32'(MEM_WE), 32'd1);
        check_val({tag, " be"}, 32'(MEM_BE), 32'(exp_be));
        check_val({tag, " wdata"}, MEM_WDATA, exp_wdata);
        check_val({tag, " addr"}, MEM_ADDR, {addr[31:2], 2'b00});
        MEM_GNT = 1'b1;
        tick();
        MEM_GNT = 1'b0;
        check_val({tag, " done"}, 32'(DONE), 32'd1);
        check_val({tag, " no wb"}, 32'(WB_WE), 32'd0);
        check_val({tag, " req drop"}, 32'(MEM_REQ), 32'd0);
        tick();
        check_val({tag, " idle"}, 32'(BUSY), 32'd0);
        $display("store %s addr=0x%08h be=%b wdata=0x%08h", tag, addr, exp_be, exp_wdata);
    endtask

    task automatic do_err(input string tag, input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [1:0] exp_cause);
        issue(ld, st, f3, addr, 32'h0, 5'd3);
        check_val({tag, " done"}, 32'(DONE), 32'd1);
        check_val({tag, " err"}, 32'(ERR), 32'd1);
        check_val({tag, " cause"}, 32'(ERR_CAUSE), 32'(exp_cause));
        check_val({tag, " no req"}, 32'(MEM_REQ), 32'd0);
        tick();
        check_val({tag, " pulse end"}, {30'd0, DONE, ERR}, 32'd0);
        check_val({tag, " cause held"}, 32'(ERR_CAUSE), 32'(exp_cause));
        $display("error %s cause=%b", tag, ERR_CAUSE);
    endtask

    initial begin
        int req_cycles;
        int guard;
        #2;
        check_val("reset outs", {23'd0, BUSY, DONE, ERR, ERR_CAUSE, MEM_REQ, MEM_WE, WB_WE, 1'b0}, 32'd0);
        check_val("reset addr", MEM_ADDR | MEM_WDATA | WB_DATA, 32'd0);
        #10 RESET_N = 1'b1;
        tick();

        do_load("T1 LW", 3'b010, 32'h104, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1);
        do_load("T2 LB", 3'b000, 32'h103, 5'd6, 32'h80112233, 32'hFFFFFF80, 1'b1);
        do_load("T2 LBU", 3'b100, 32'h103, 5'd6, 32'h80112233, 32'h00000080, 1'b1);
        do_load("T2 LH", 3'b001, 32'h102, 5'd9, 32'h80112233, 32'hFFFF8011, 1'b1);
        do_load("LHU lo", 3'b101, 32'h100, 5'd9, 32'h8011A233, 32'h0000A233, 1'b1);
        do_load("LB lane1", 3'b000, 32'h201, 5'd1, 32'h00007F00, 32'h0000007F, 1'b1);

        do_store("T3 SB", 3'b000, 32'h101, 32'h000000AB, 4'b0010, 32'hABABABAB);
        do_store("SH hi", 3'b001, 32'h102, 32'h1234CDEF, 4'b1100, 32'hCDEFCDEF);
        do_store("SH lo", 3'b001, 32'h300, 32'h00005678, 4'b0011, 32'h56785678);
        do_store("SW", 3'b010, 32'h108, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D);

        do_err("T4 LW mis", 1'b1, 1'b0, 3'b010, 32'h102, 2'b01);
        do_err("T4 LD f3=011", 1'b1, 1'b0, 3'b011, 32'h100, 2'b10);
        do_err("LH mis", 1'b1, 1'b0, 3'b001, 32'h101, 2'b01);
        do_err("SB f3=100", 1'b0, 1'b1, 3'b100, 32'h100, 2'b10);
        do_err("both ops", 1'b1, 1'b1, 3'b010, 32'h100, 2'b10);
        do_err("illegal over mis", 1'b1, 1'b0, 3'b110, 32'h103, 2'b10);

        // START with neither op set is ignored and leaves the old cause in place
        issue(1'b0, 1'b0, 3'b010, 32'h100, 32'h0, 5'd1);
        check_val("noop busy", 32'(BUSY), 32'd0);
        check_val("noop cause", 32'(ERR_CAUSE), 32'd2);
        do_load("cause clr", 3'b010, 32'h10, 5'd2, 32'h11112222, 32'h11112222, 1'b1);
        check_val("cause cleared", 32'(ERR_CAUSE), 32'd0);

        // T5: grant never arrives; a second START mid-request must not disturb it
        issue(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 5'd4);
        req_cycles = 0;
        guard = 0;
        while (!DONE && guard < 40) begin
            if (MEM_REQ) req_cycles++;
            if (guard == 3) begin
                START = 1'b1; OP_STORE = 1'b1; FUNCT3 = 3'b010; ADDR = 32'h400;
            end else begin
                START = 1'b0; OP_STORE = 1'b0;
            end
            tick();
            guard++;
        end
        check_val("T5 done seen", 32'(DONE), 32'd1);
        check_val("T5 req cycles", 32'(req_cycles), 32'd16);
        check_val("T5 err", 32'(ERR), 32'd1);
        check_val("T5 cause", 32'(ERR_CAUSE), 32'd3);
        check_val("T5 req low", 32'(MEM_REQ), 32'd0);
        check_val("T5 addr kept", MEM_ADDR, 32'h200);
        check_val("T5 we kept", 32'(MEM_WE), 32'd0);
        $display("timeout req_cycles=%0d cause=%b", req_cycles, ERR_CAUSE);
        tick();

        // T6: async reset while waiting for read data
        issue(1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 5'd8);
        MEM_GNT = 1'b1;
        tick();
        MEM_GNT = 1'b0;
        check_val("T6 in wait", 32'(BUSY), 32'd1);
        #2 RESET_N = 1'b0;
        #1;
        check_val("T6 async outs", {23'd0, BUSY, DONE, ERR, ERR_CAUSE, MEM_REQ, MEM_WE, WB_WE, 1'b0}, 32'd0);
        check_val("T6 async data", MEM_ADDR | MEM_WDATA | WB_DATA, 32'd0);
        #3 RESET_N = 1'b1;
        MEM_RVALID = 1'b1; MEM_RDATA = 32'h12345678;
        tick();
        MEM_RVALID = 1'b0;
        check_val("T6 late rvalid", {30'd0, WB_WE, DONE}, 32'd0);
        tick();
        check_val("T6 still idle", {30'd0, WB_WE, BUSY}, 32'd0);
        $display("reset mid-op: outputs cleared, late rvalid ignored");

        do_load("T6 RD0", 3'b010, 32'h600, 5'd0, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
